// File: rtl/la_ioringctl.sv
// Serial configuration master for the IO ring: shifts valid/ready config words
// MSB first onto sclk/sdata, then pulses a ring-wide latch once per chain.
module la_ioringctl #(
  parameter int RINGW  = 8,
  parameter int CFGW   = 16,
  parameter int NCELLS = 32,
  parameter int DIV    = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFGW-1:0]  cfg_data,
  input  logic             cfg_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RINGW-1:0] ioring
);

  localparam int PW = (2 * DIV > 2) ? $clog2(2 * DIV) : 1;
  localparam int BW = (CFGW > 2) ? $clog2(CFGW) : 1;
  localparam int WW = $clog2(NCELLS + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] LAT_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFGW - 1);
  localparam logic [WW-1:0] W_MAX    = WW'(NCELLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t          state_reg, state_next;
  logic [CFGW-1:0] shreg_reg, shreg_next;
  logic [PW-1:0]   ph_reg, ph_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic [WW-1:0]   wcnt_reg, wcnt_next;
  logic            last_reg, last_next;
  logic            ready_reg, ready_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic            sclk_reg, sclk_next;
  logic            sdata_reg, sdata_next;
  logic            latch_reg, latch_next;
  logic            rnrst_reg, rnrst_next;

  logic            accept;
  logic [CFGW-1:0] sh_shifted;

  assign accept     = cfg_valid && ready_reg;
  assign sh_shifted = shreg_reg << 1;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg <= S_IDLE;
      shreg_reg <= '0;
      ph_reg    <= '0;
      bit_reg   <= '0;
      wcnt_reg  <= '0;
      last_reg  <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      sclk_reg  <= 1'b0;
      sdata_reg <= 1'b0;
      latch_reg <= 1'b0;
      rnrst_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      ph_reg    <= ph_next;
      bit_reg   <= bit_next;
      wcnt_reg  <= wcnt_next;
      last_reg  <= last_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      sclk_reg  <= sclk_next;
      sdata_reg <= sdata_next;
      latch_reg <= latch_next;
      rnrst_reg <= rnrst_next;
    end
  end

  // All outputs are computed here for the following cycle and registered.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    ph_next    = ph_reg;
    bit_next   = bit_reg;
    wcnt_next  = wcnt_reg;
    last_next  = last_reg;
    ready_next = ready_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    sclk_next  = sclk_reg;
    sdata_next = sdata_reg;
    latch_next = latch_reg;
    rnrst_next = 1'b1;

    case (state_reg)
      S_IDLE, S_WAIT: begin
        ready_next = 1'b1;
        busy_next  = (state_reg == S_WAIT);
        if (accept) begin
          state_next = S_SHIFT;
          shreg_next = cfg_data;
          last_next  = cfg_last;
          sdata_next = cfg_data[CFGW-1];
          sclk_next  = 1'b0;
          ph_next    = '0;
          bit_next   = '0;
          ready_next = 1'b0;
          busy_next  = 1'b1;
          if (state_reg == S_IDLE) begin
            err_next  = 1'b0;
            wcnt_next = WW'(1);
          end else begin
            wcnt_next = wcnt_reg + WW'(1);
          end
        end
      end

      S_SHIFT: begin
        if (ph_reg == PH_LAST) begin
          ph_next   = '0;
          sclk_next = 1'b0;
          if (bit_reg == BIT_LAST) begin
            sdata_next = 1'b0;
            if (last_reg || (wcnt_reg == W_MAX)) begin
              state_next = S_LATCH;
              latch_next = 1'b1;
              err_next   = err_reg | ~last_reg;
            end else begin
              state_next = S_WAIT;
              ready_next = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + BW'(1);
            shreg_next = sh_shifted;
            sdata_next = sh_shifted[CFGW-1];
          end
        end else begin
          ph_next   = ph_reg + PW'(1);
          sclk_next = ((int'(ph_reg) + 1) >= DIV);
        end
      end

      S_LATCH: begin
        if (ph_reg == LAT_LAST) begin
          state_next = S_IDLE;
          latch_next = 1'b0;
          done_next  = 1'b1;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          wcnt_next  = '0;
          ph_next    = '0;
        end else begin
          ph_next = ph_reg + PW'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign cfg_ready = ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  assign ioring[0] = sclk_reg;
  assign ioring[1] = sdata_reg;
  assign ioring[2] = latch_reg;
  assign ioring[3] = rnrst_reg;

  generate
    for (genvar gi = 4; gi < RINGW; gi++) begin : g_unused
      assign ioring[gi] = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_la_ioringctl.sv
// Bench for la_ioringctl: directed scenarios plus random traffic, checked every
// cycle against a timeline model of the serial ring protocol.
module tb_la_ioringctl;

  localparam int RINGW  = 8;
  localparam int CFGW   = 4;
  localparam int NCELLS = 3;
  localparam int DIV    = 2;

  localparam int M_RST   = 0;
  localparam int M_IDLE  = 1;
  localparam int M_SHIFT = 2;
  localparam int M_WAIT  = 3;
  localparam int M_LATCH = 4;

  logic             clk = 1'b0;
  logic             nreset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFGW-1:0]  cfg_data;
  logic             cfg_last;
  logic             busy;
  logic             done;
  logic             err;
  logic [RINGW-1:0] ioring;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase of the chain, cycles elapsed in it, current word, chain size.
  int              m_mode;
  int              m_t;
  int              m_nw;
  logic [CFGW-1:0] m_word;
  logic            m_last;
  logic            m_err;
  logic            m_done;

  la_ioringctl #(
    .RINGW (RINGW),
    .CFGW  (CFGW),
    .NCELLS(NCELLS),
    .DIV   (DIV)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ioring   (ioring)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [RINGW-1:0] e_ring;
    e_ring = '0;
    if (m_mode == M_SHIFT) begin
      e_ring[0] = ((m_t % (2 * DIV)) >= DIV);
      e_ring[1] = m_word[CFGW-1-(m_t/(2*DIV))];
    end
    e_ring[2] = (m_mode == M_LATCH);
    e_ring[3] = (m_mode != M_RST);
    chk("ioring", 32'(ioring), 32'(e_ring));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == M_IDLE || m_mode == M_WAIT));
    chk("busy", 32'(busy), 32'(m_mode == M_SHIFT || m_mode == M_WAIT || m_mode == M_LATCH));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_step(input logic nr, input logic v, input logic [CFGW-1:0] d,
                            input logic l, output bit hs);
    hs = 1'b0;
    if (!nr) begin
      m_mode = M_RST;
      m_err  = 1'b0;
      m_done = 1'b0;
      m_nw   = 0;
      return;
    end
    m_done = 1'b0;
    case (m_mode)
      M_RST: m_mode = M_IDLE;
      M_IDLE, M_WAIT: begin
        if (v) begin
          hs = 1'b1;
          if (m_mode == M_IDLE) begin
            m_err = 1'b0;
            m_nw  = 0;
          end
          m_nw++;
          m_word = d;
          m_last = l;
          m_t    = 0;
          m_mode = M_SHIFT;
          $display("xfer word=%h last=%0d index=%0d t=%0t", d, l, m_nw, $time);
        end
      end
      M_SHIFT: begin
        m_t++;
        if (m_t == 2 * DIV * CFGW) begin
          if (m_last || m_nw == NCELLS) begin
            if (!m_last) m_err = 1'b1;
            m_mode = M_LATCH;
            m_t    = 0;
          end else begin
            m_mode = M_WAIT;
          end
        end
      end
      M_LATCH: begin
        m_t++;
        if (m_t == DIV) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
          $display("latch chain words=%0d err=%0d t=%0t", m_nw, m_err, $time);
        end
      end
      default: m_mode = M_RST;
    endcase
  endtask

  // One clock: check current outputs, apply inputs for the next edge, advance model.
  task automatic cyc(input logic nr, input logic v, input logic [CFGW-1:0] d,
                     input logic l, output bit hs);
    check_outputs();
    nreset    = nr;
    cfg_valid = v;
    cfg_data  = d;
    cfg_last  = l;
    model_step(nr, v, d, l, hs);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit hs;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, CFGW'($urandom), 1'($urandom), hs);
  endtask

  task automatic send(input logic [CFGW-1:0] d, input logic l);
    bit hs;
    hs = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) cyc(1'b1, 1'b1, d, l, hs);
    if (!hs) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_chain_end();
    int i;
    i = 0;
    while ((m_mode == M_SHIFT || m_mode == M_LATCH) && i < 200) begin
      idle_cycles(1);
      i++;
    end
    if (i >= 200) chk("chain_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset(input int n);
    bit hs;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, hs);
  endtask

  initial begin
    bit hs;
    nreset    = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    m_mode = M_RST; m_t = 0; m_nw = 0; m_word = '0;
    m_last = 1'b0;  m_err = 1'b0; m_done = 1'b0;
    @(negedge clk);

    do_reset(3);
    idle_cycles(3);

    send(4'b1010, 1'b1);
    wait_chain_end();
    idle_cycles(3);

    send(4'b1100, 1'b0);
    wait_chain_end();
    idle_cycles(5);
    send(4'b0011, 1'b1);
    wait_chain_end();
    idle_cycles(2);

    for (int w = 0; w < NCELLS; w++) begin
      send(CFGW'($urandom), 1'b0);
      wait_chain_end();
      idle_cycles(w);
    end
    idle_cycles(2);
    send(4'b0110, 1'b1);
    wait_chain_end();
    idle_cycles(2);

    send(4'b1001, 1'b1);
    idle_cycles(DIV * 2 + 1);
    do_reset(2);
    idle_cycles(4);
    send(4'b0101, 1'b1);
    wait_chain_end();
    idle_cycles(2);

    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b1, CFGW'($urandom), 1'($urandom_range(0, 3) == 0), hs);
    wait_chain_end();
    idle_cycles(3);

    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 2) == 0),
          CFGW'($urandom), 1'($urandom_range(0, 2) == 0), hs);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
